// File: rtl/fft_pkg.sv
// Shared types for the in-place radix-2 DIF FFT control and datapath.
// The optional inverse-transform ports are enabled by the FFT_INVERSE_EN macro.
package fft_pkg;

    localparam int LOG2N_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_state_t;

    // Packed complex sample: real in the upper half, imaginary in the lower half.
    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    function automatic cplx_t cplx_make(input logic signed [15:0] re,
                                        input logic signed [15:0] im);
        cplx_t c;
        c.re = re;
        c.im = im;
        return c;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly addressing for stage s, butterfly j of an in-place
// radix-2 DIF FFT: a/b operand addresses and the twiddle index k<<s.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEFAULT
) (
    input  logic [$clog2(LOG2N)-1:0] s,
    input  logic [LOG2N-2:0]         j,
    output logic [LOG2N-1:0]         a,
    output logic [LOG2N-1:0]         b,
    output logic [LOG2N-2:0]         tw
);

    localparam int S_W = $clog2(LOG2N);
    localparam logic [S_W-1:0]   S_LAST = S_W'(LOG2N - 1);
    localparam logic [LOG2N-1:0] ONE    = LOG2N'(1);

    logic [S_W-1:0]   sh;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] mask_lo;
    logic [LOG2N-1:0] j_ext;
    logic [LOG2N-1:0] k;
    logic [LOG2N-1:0] hi;

    // span is a power of two, so j/span and j%span reduce to masking; the
    // group index is then doubled by a left shift to skip over the b half.
    always_comb begin
        sh      = S_LAST - s;
        span    = ONE << sh;
        mask_lo = span - ONE;
        j_ext   = {1'b0, j};
        k       = j_ext & mask_lo;
        hi      = (j_ext & ~mask_lo) << 1;
        a       = hi | k;
        b       = a | span;
        tw      = k[LOG2N-2:0] << s;
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly sequencer for an in-place radix-2 DIF FFT over a dual-port RAM.
// Define FFT_INVERSE_EN to add the inverse/tw_conj ports for an unscaled IFFT.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef FFT_INVERSE_EN
    input  logic             inverse,
    output logic             tw_conj,
`endif
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_idx,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b
);

    localparam int S_W = $clog2(LOG2N);
    localparam int J_W = LOG2N - 1;
    localparam logic [S_W-1:0] S_LAST = S_W'(LOG2N - 1);
    localparam logic [J_W-1:0] J_LAST = '1;

    fft_state_t       state_q, state_d;
    logic [S_W-1:0]   s_q, s_d;
    logic [J_W-1:0]   j_q, j_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rd_en_q, rd_en_d;
    logic [LOG2N-1:0] rd_addr_a_q, rd_addr_a_d;
    logic [LOG2N-1:0] rd_addr_b_q, rd_addr_b_d;
    logic [J_W-1:0]   tw_idx_q, tw_idx_d;
    logic             wr_en_q, wr_en_d;
    logic [LOG2N-1:0] wr_addr_a_q, wr_addr_a_d;
    logic [LOG2N-1:0] wr_addr_b_q, wr_addr_b_d;
`ifdef FFT_INVERSE_EN
    logic             conj_q, conj_d;
`endif

    logic [LOG2N-1:0] gen_a;
    logic [LOG2N-1:0] gen_b;
    logic [J_W-1:0]   gen_tw;

    // Addresses are generated from the next (s, j) so the read strobe and its
    // addresses leave the flops together in the cycle the butterfly is issued.
    fft_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .s  (s_d),
        .j  (j_d),
        .a  (gen_a),
        .b  (gen_b),
        .tw (gen_tw)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        rd_en_d = 1'b0;
        done_d  = 1'b0;
`ifdef FFT_INVERSE_EN
        conj_d  = conj_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    j_d     = '0;
                    rd_en_d = 1'b1;
`ifdef FFT_INVERSE_EN
                    conj_d  = inverse;
`endif
                end
            end
            ST_RUN: begin
                if (j_q == J_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    j_d     = j_q + 1'b1;
                    rd_en_d = 1'b1;
                end
            end
            // No read here: the stage's last write lands before the next
            // stage reads any of the locations it just produced.
            ST_DRAIN: begin
                j_d = '0;
                if (s_q != S_LAST) begin
                    state_d = ST_RUN;
                    s_d     = s_q + 1'b1;
                    rd_en_d = 1'b1;
                end else begin
                    state_d = ST_DONE;
                    s_d     = '0;
                    done_d  = 1'b1;
`ifdef FFT_INVERSE_EN
                    conj_d  = 1'b0;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
                j_d     = '0;
            end
        endcase
    end

    always_comb begin
        busy_d      = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        rd_addr_a_d = rd_en_d ? gen_a  : '0;
        rd_addr_b_d = rd_en_d ? gen_b  : '0;
        tw_idx_d    = rd_en_d ? gen_tw : '0;
        wr_en_d     = rd_en_q;
        wr_addr_a_d = rd_addr_a_q;
        wr_addr_b_d = rd_addr_b_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            j_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            tw_idx_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_a_q <= '0;
            wr_addr_b_q <= '0;
`ifdef FFT_INVERSE_EN
            conj_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            j_q         <= j_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            tw_idx_q    <= tw_idx_d;
            wr_en_q     <= wr_en_d;
            wr_addr_a_q <= wr_addr_a_d;
            wr_addr_b_q <= wr_addr_b_d;
`ifdef FFT_INVERSE_EN
            conj_q      <= conj_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign tw_idx    = tw_idx_q;
    assign wr_en     = wr_en_q;
    assign wr_addr_a = wr_addr_a_q;
    assign wr_addr_b = wr_addr_b_q;
`ifdef FFT_INVERSE_EN
    assign tw_conj   = conj_q;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer (N=16): per-cycle scoreboard of all outputs,
// plus an end-to-end impulse transform through a behavioural RAM and butterfly.
module tb_fft_stage_sequencer;
    import fft_pkg::*;

    localparam int L = 4;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done, rd_en, wr_en;
    logic [L-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [L-2:0] tw_idx;
    logic conj_obs;
`ifdef FFT_INVERSE_EN
    logic inverse = 1'b0;
    logic tw_conj;
    assign conj_obs = tw_conj;
`else
    assign conj_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    fft_stage_sequencer #(.LOG2N(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef FFT_INVERSE_EN
        .inverse   (inverse),
        .tw_conj   (tw_conj),
`endif
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_idx    (tw_idx),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    // {busy, done, rd_en, ra, rb, tw, wr_en, wa, wb, conj}
    logic [23:0] obs;
    assign obs = {busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx,
                  wr_en, wr_addr_a, wr_addr_b, conj_obs};

    logic [23:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Behavioural RAM (1-cycle read latency), combinational butterfly, W = 0x7FFF + j0.
    cplx_t ram [N];
    cplx_t rd_a_q, rd_b_q;
    cplx_t bf_out1, bf_out2;
    logic ram_init = 1'b0;

    always_comb begin
        int ar, ai, br, bi, dr, di;
        ar = int'(rd_a_q.re); ai = int'(rd_a_q.im);
        br = int'(rd_b_q.re); bi = int'(rd_b_q.im);
        dr = ar - br;
        di = ai - bi;
        bf_out1.re = 16'(ar + br);
        bf_out1.im = 16'(ai + bi);
        bf_out2.re = 16'((dr * 32767 + 16384) >>> 15);
        bf_out2.im = 16'((di * 32767 + 16384) >>> 15);
    end

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < N; i++) ram[i] <= (i == 0) ? 32'h0100_0000 : 32'h0;
        end else begin
            if (rd_en) begin
                rd_a_q <= ram[rd_addr_a];
                rd_b_q <= ram[rd_addr_b];
            end
            if (wr_en) begin
                ram[wr_addr_a] <= bf_out1;
                ram[wr_addr_b] <= bf_out2;
            end
        end
    end

    function automatic logic [23:0] rec(input logic bz, input logic dn, input logic re,
                                        input int a, input int b, input int tw,
                                        input logic we, input int wa, input int wb,
                                        input logic cj);
        return {bz, dn, re, 4'(a), 4'(b), 3'(tw), we, 4'(wa), 4'(wb), cj};
    endfunction

    // Expected outputs for cycles 1..38 of one transform, from the textbook
    // addressing formulas.
    task automatic push_transform(input logic cj);
        logic pr;
        int pa, pb, span, k, a, b, tw;
        pr = 1'b0; pa = 0; pb = 0;
        for (int s = 0; s < L; s++) begin
            for (int j = 0; j < N / 2; j++) begin
                span = N >> (s + 1);
                k    = j % span;
                a    = (j / span) * 2 * span + k;
                b    = a + span;
                tw   = k << s;
                exp_q.push_back(rec(1'b1, 1'b0, 1'b1, a, b, tw, pr, pa, pb, cj));
                pr = 1'b1; pa = a; pb = b;
            end
            exp_q.push_back(rec(1'b1, 1'b0, 1'b0, 0, 0, 0, pr, pa, pb, cj));
            pr = 1'b0; pa = 0; pb = 0;
        end
        exp_q.push_back(rec(1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b0));
        exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b0));
    endtask

    task automatic launch(input logic cj);
        @(negedge clk);
        start = 1'b1;
`ifdef FFT_INVERSE_EN
        inverse = cj;
`endif
        @(posedge clk);
        push_transform(cj);
        #1;
        start = 1'b0;
`ifdef FFT_INVERSE_EN
        inverse = 1'b0;
`endif
    endtask

    task automatic test_reset();
        logic [23:0] e;
        repeat (2) @(posedge clk);
        #1;
        e = '0;
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL reset_hold obs=%h expected=%h", obs, e);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL reset_release obs=%h expected=%h", obs, e);
        end
    endtask

    task automatic test_schedule();
        logic [23:0] e;
        launch(1'b0);
        for (int c = 1; c <= 38; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL sched_cycle%0d obs=%h expected=%h", c, obs, e);
            end
            start = (c == 5) || (c == 37);
        end
        start = 1'b0;
        e = '0;
        for (int c = 39; c <= 41; c++) begin
            @(negedge clk);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL ignored_start_cycle%0d obs=%h expected=%h", c, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [23:0] e;
        launch(1'b0);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL prereset_cycle%0d obs=%h expected=%h", c, obs, e);
            end
        end
        #1;
        exp_q.delete();
        rst = 1'b1;
        #1;
        e = '0;
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL async_reset obs=%h expected=%h", obs, e);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL post_reset_idle obs=%h expected=%h", obs, e);
        end
        launch(1'b0);
        for (int c = 1; c <= 38; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL restart_cycle%0d obs=%h expected=%h", c, obs, e);
            end
        end
    endtask

    task automatic test_end_to_end();
        logic [23:0] e;
        @(negedge clk);
        ram_init = 1'b1;
        @(negedge clk);
        ram_init = 1'b0;
        launch(1'b0);
        for (int c = 1; c <= 38; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL e2e_cycle%0d obs=%h expected=%h", c, obs, e);
            end
        end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (ram[i] !== 32'h0100_0000) begin
                miscompares++;
                $display("FAIL bin%0d got=%h expected=%h", i, ram[i], 32'h0100_0000);
            end
        end
    endtask

`ifdef FFT_INVERSE_EN
    task automatic test_inverse();
        logic [23:0] e;
        launch(1'b1);
        for (int c = 1; c <= 38; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL inverse_cycle%0d obs=%h expected=%h", c, obs, e);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_schedule();
        test_reset_mid_run();
        test_end_to_end();
`ifdef FFT_INVERSE_EN
        test_inverse();
`endif
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
